noc_traffic_pe: RTL
===================

NOC_TRAFFIC_PE -- requirements
Module: noc_traffic_pe

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning.
- X, 2: mesh columns.
- Y, 2: mesh rows.
- x_size, 1: dest-x field bits.
- y_size, 1: dest-y field bits.
- data_width, 256: payload bits; SHALL be >= 64+x_size+y_size.
- MY_X, 0: own column.
- MY_Y, 0: own row.
- NUM_PACKETS, 10000: packets to send, 32-bit.
- RATE, 256: injection probability RATE/256 per decision, 0..256.
- MODE, 0: traffic pattern; 0 uniform, 1 complement, 2 hotspot.
- HOT_X, 0: hotspot column.
- HOT_Y, 0: hotspot row.
- SEED, 32'hACE1_2468: LFSR seed, nonzero.
REQ-002 SHALL have ports, one per line: name, direction, width, meaning.
- clk, in, 1: single clock.
- rstn, in, 1: asynchronous active-low reset.
- start, in, 1: level enable for injection.
- r_valid_pe, out, 1: packet offered to NoC.
- r_data_pe, out, x_size+y_size+data_width: offered packet.
- r_ready_pe, in, 1: NoC accepts.
- w_valid_pe, in, 1: packet delivered; no backpressure.
- w_data_pe, in, x_size+y_size+data_width: delivered packet.
- done, out, 1: all own packets sent.
- sent_cnt, out, 32: packets handed to NoC.
- recv_cnt, out, 32: packets received.
- err_cnt, out, 16: misrouted packets, saturating.
- lat_max, out, 32: maximum observed latency.
- lat_sum, out, 48: accumulated latency, saturating.

Function
REQ-003 Packet layout SHALL be: [x_size-1:0] dest x; next y_size bits dest y; payload above. Payload bits [31:0] = injection timestamp, [63:32] = sequence number (0-based), then src x, then src y.
REQ-004 A 32-bit Galois LFSR (taps 32,22,2,1) SHALL advance every cycle after reset; SEED is loaded on reset.
REQ-005 FSM states SHALL be IDLE, RUN, FIN. IDLE->RUN when start=1. RUN->FIN on the handshake of the last packet. FIN is held until reset. start=0 in RUN SHALL suppress new decisions; a held packet is still completed.
REQ-006 In RUN, one injection decision SHALL be made per cycle in which the output register is empty or being emptied (r_valid_pe & r_ready_pe). Inject when lfsr[7:0] < RATE; RATE=256 always injects.
REQ-007 Destination: MODE 0 uses lfsr[15:8] mod 2^x_size and lfsr[23:16] mod 2^y_size. A decision whose candidate has x>=X, y>=Y or equals self SHALL be discarded without injecting. MODE 1 uses (X-1-MY_X, Y-1-MY_Y). MODE 2 uses (HOT_X, HOT_Y).
REQ-008 If the MODE 1/2 destination equals self, the effective packet target SHALL be 0. With NUM_PACKETS=0 or a target of 0, the block SHALL enter FIN on the first RUN cycle.
REQ-009 An accepted decision SHALL register the packet so r_valid_pe rises on the next edge. Data SHALL be held stable while valid and not ready. Back-to-back packets SHALL be possible (one per cycle at RATE=256 with ready held high).
REQ-010 sent_cnt SHALL increment on each r_valid_pe & r_ready_pe. done SHALL be 1 exactly in FIN.
REQ-011 A 32-bit cycle counter SHALL free-run from reset and wrap. On w_valid_pe: recv_cnt+1; latency = (now - timestamp) mod 2^32; lat_sum += latency, saturating at all-ones; lat_max updated if larger.
REQ-012 If a received packet's dest != (MY_X, MY_Y), err_cnt SHALL increment, saturating at 16'hFFFF. Its latency is still accumulated.
REQ-013 Receive logic SHALL operate in every state, including IDLE and FIN.

Reset
REQ-014 On rstn=0, asynchronously: state IDLE; r_valid_pe=0; r_data_pe=0; done=0; all counters, lat_max and lat_sum = 0; LFSR = SEED; cycle counter = 0. Any in-flight offered packet SHALL be dropped.

Verification
REQ-015 MODE 2, HOT=(1,1), node (0,0), NUM_PACKETS=4, RATE=256, ready=1 -> 4 consecutive valid cycles; sequence 0..3; dest (1,1); done on the cycle after the 4th handshake; sent_cnt=4.
REQ-016 Ready held 0 for 5 cycles with valid high -> r_data_pe is unchanged across all 5 cycles; sent_cnt increments once, only on release.
REQ-017 MODE 0, X=Y=2, 1000 packets, RATE=64 -> no dest equals self or is out of range; the observed injection ratio is within 25%±5% of decisions.
REQ-018 Inject w_data_pe with dest (1,0) at node (0,0), timestamp = now-7 -> recv_cnt=1, err_cnt=1, lat_max=7, lat_sum=7.
REQ-019 Assert rstn=0 mid-HOLD, between clock edges -> r_valid_pe drops immediately; all counters read 0; after release with start=1, the first packet has sequence 0.
REQ-020 MODE 1, X=Y=3, node (1,1) -> done=1 one cycle after start; r_valid_pe never asserted.

Source files
------------

// File: rtl/noc_traffic_pe.sv
// noc_traffic_pe: synthetic traffic generator and latency sink for one mesh node.
// The transmit side offers packets to the NoC through a valid/ready register
// paced by a 32-bit Galois LFSR. The receive side counts delivered packets,
// flags misrouted ones and accumulates end-to-end latency using the injection
// timestamp carried in the payload.
//
// Packet layout (low to high):
//   [x_size-1:0]            destination x
//   next y_size bits        destination y
//   payload bits [31:0]     injection timestamp (cycle counter)
//   payload bits [63:32]    sequence number, 0-based
//   then source x (x_size bits), then source y (y_size bits), rest zero
// data_width must be at least 64 + x_size + y_size.
// The random destination fields are taken from 8-bit LFSR slices, so x_size
// and y_size are expected to be 8 or less.
module noc_traffic_pe #(
  parameter int          X           = 2,
  parameter int          Y           = 2,
  parameter int          x_size      = 1,
  parameter int          y_size      = 1,
  parameter int          data_width  = 256,
  parameter int          MY_X        = 0,
  parameter int          MY_Y        = 0,
  parameter int unsigned NUM_PACKETS = 10000,
  parameter int          RATE        = 256,
  parameter int          MODE        = 0,
  parameter int          HOT_X       = 0,
  parameter int          HOT_Y       = 0,
  parameter logic [31:0] SEED        = 32'hACE1_2468
) (
  input  logic                                 clk,
  input  logic                                 rstn,
  input  logic                                 start,
  output logic                                 r_valid_pe,
  output logic [x_size+y_size+data_width-1:0] r_data_pe,
  input  logic                                 r_ready_pe,
  input  logic                                 w_valid_pe,
  input  logic [x_size+y_size+data_width-1:0] w_data_pe,
  output logic                                 done,
  output logic [31:0]                          sent_cnt,
  output logic [31:0]                          recv_cnt,
  output logic [15:0]                          err_cnt,
  output logic [31:0]                          lat_max,
  output logic [47:0]                          lat_sum
);

  // Header width and total packet width.
  localparam int HW = x_size + y_size;
  localparam int PW = HW + data_width;

  // Galois feedback mask for taps 32, 22, 2, 1 (right-shifting form).
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  // Fixed destination used by the complement and hotspot patterns.
  localparam int FIX_X = (MODE == 1) ? (X - 1 - MY_X) : HOT_X;
  localparam int FIX_Y = (MODE == 1) ? (Y - 1 - MY_Y) : HOT_Y;

  // A fixed pattern that points back at this node has nothing to send.
  localparam bit FIX_SELF = (MODE != 0) && (FIX_X == MY_X) && (FIX_Y == MY_Y);
  localparam logic [31:0] TARGET = FIX_SELF ? 32'd0 : 32'(NUM_PACKETS);

  // RATE is 0..256, so a 9-bit compare against the 8-bit LFSR slice lets
  // RATE=256 inject on every decision and RATE=0 never inject.
  localparam logic [8:0] RATE_L = 9'(RATE);

  localparam logic [x_size-1:0] MY_XL  = x_size'(MY_X);
  localparam logic [y_size-1:0] MY_YL  = y_size'(MY_Y);
  localparam logic [x_size-1:0] FIX_XL = x_size'(FIX_X);
  localparam logic [y_size-1:0] FIX_YL = y_size'(FIX_Y);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] lfsr;
  logic [31:0] cyc;
  logic [31:0] seq;

  // Transmit-side decision signals.
  logic              handshake;
  logic              slot_free;
  logic              rate_ok;
  logic              dest_ok;
  logic              fire;
  logic              last_hs;
  logic [x_size-1:0] cand_x;
  logic [y_size-1:0] cand_y;
  logic [PW-1:0]     pkt;

  // Receive-side datapath.
  logic [31:0] rx_ts;
  logic [31:0] rx_lat;
  logic [48:0] rx_sum;
  logic        rx_bad;

  // Payload bits beyond the timestamp carry nothing the sink needs.
  logic unused_rx;
  assign unused_rx = ^w_data_pe[PW-1:HW+32];

  // Injection decision and candidate packet for the current cycle.
  // NOTE: every signal gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    cand_x    = FIX_XL;
    cand_y    = FIX_YL;
    dest_ok   = 1'b1;
    handshake = r_valid_pe & r_ready_pe;
    slot_free = ~r_valid_pe | r_ready_pe;
    rate_ok   = ({1'b0, lfsr[7:0]} < RATE_L);

    if (MODE == 0) begin
      cand_x  = lfsr[8 +: x_size];
      cand_y  = lfsr[16 +: y_size];
      dest_ok = (32'(cand_x) < 32'(X)) && (32'(cand_y) < 32'(Y)) &&
                !((cand_x == MY_XL) && (cand_y == MY_YL));
    end

    fire    = (state == RUN) && start && slot_free && (seq < TARGET) &&
              rate_ok && dest_ok;
    last_hs = handshake && (sent_cnt == TARGET - 32'd1);

    pkt                           = '0;
    pkt[x_size-1:0]               = cand_x;
    pkt[x_size +: y_size]         = cand_y;
    pkt[HW +: 32]                 = cyc;
    pkt[HW+32 +: 32]              = seq;
    pkt[HW+64 +: x_size]          = MY_XL;
    pkt[HW+64+x_size +: y_size]   = MY_YL;
  end

  // Latency, saturating sum and routing check for the delivered packet.
  always_comb begin
    rx_ts  = w_data_pe[HW +: 32];
    rx_lat = cyc - rx_ts;
    rx_sum = {1'b0, lat_sum} + 49'(rx_lat);
    rx_bad = (w_data_pe[x_size-1:0] != MY_XL) ||
             (w_data_pe[x_size +: y_size] != MY_YL);
  end

  // Free-running LFSR and cycle counter; both restart from their seeds on reset.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lfsr <= SEED;
      cyc  <= 32'd0;
    end else begin
      lfsr <= {1'b0, lfsr[31:1]} ^ ({32{lfsr[0]}} & LFSR_TAPS);
      cyc  <= cyc + 32'd1;
    end
  end

  // Control FSM: wait for start, inject until the last packet is accepted, then park.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
          end
        end
        RUN: begin
          if ((TARGET == 32'd0) || last_hs) begin
            state <= FIN;
            done  <= 1'b1;
          end
        end
        FIN: begin
          state <= FIN;
        end
        default: begin
          state <= IDLE;
          done  <= 1'b0;
        end
      endcase
    end
  end

  // Output register: load on an accepted decision, clear once drained, else hold.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_valid_pe <= 1'b0;
      r_data_pe  <= '0;
      seq        <= 32'd0;
    end else if (fire) begin
      r_valid_pe <= 1'b1;
      r_data_pe  <= pkt;
      seq        <= seq + 32'd1;
    end else if (handshake) begin
      r_valid_pe <= 1'b0;
    end
  end

  // Count packets the NoC has taken from the output register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sent_cnt <= 32'd0;
    end else if (handshake) begin
      sent_cnt <= sent_cnt + 32'd1;
    end
  end

  // Sink statistics; active in every FSM state since delivery has no backpressure.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      recv_cnt <= 32'd0;
      err_cnt  <= 16'd0;
      lat_max  <= 32'd0;
      lat_sum  <= 48'd0;
    end else if (w_valid_pe) begin
      recv_cnt <= recv_cnt + 32'd1;
      if (rx_bad && (err_cnt != 16'hFFFF)) begin
        err_cnt <= err_cnt + 16'd1;
      end
      lat_sum <= rx_sum[48] ? {48{1'b1}} : rx_sum[47:0];
      if (rx_lat > lat_max) begin
        lat_max <= rx_lat;
      end
    end
  end

endmodule
